// File: rtl/mdu_defs.sv
// Package for the multiply/divide unit: opcode encodings and default latencies.
package mdu_defs;

   localparam int unsigned MDU_WIDTH_DEF      = 32;
   localparam int unsigned MDU_MUL_CYCLES_DEF = 5;
   localparam int unsigned MDU_DIV_CYCLES_DEF = 10;
   localparam int unsigned MDU_OP_W           = 4;

   typedef enum logic [MDU_OP_W-1:0] {
      OP_MULT  = 4'b0000,
      OP_MULTU = 4'b0001,
      OP_DIV   = 4'b0010,
      OP_DIVU  = 4'b0011,
      OP_MTHI  = 4'b0100,
      OP_MTLO  = 4'b0101,
      OP_MFHI  = 4'b0110,
      OP_MFLO  = 4'b0111,
      OP_MADD  = 4'b1000,
      OP_MADDU = 4'b1001,
      OP_MSUB  = 4'b1010,
      OP_MSUBU = 4'b1011,
      OP_NOP   = 4'b1111
   } mdu_op_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 2*WIDTH arithmetic result {hi,lo} for one MDU operation.
// Divide by zero yields lo = all ones, hi = dividend.
module mdu_arith
   import mdu_defs::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH_DEF
) (
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   hi,
   input  logic [WIDTH-1:0]   lo,
   output logic [2*WIDTH-1:0] result_c
);

   localparam int unsigned W2 = 2 * WIDTH;

   logic [W2-1:0]    prod_s;
   logic [W2-1:0]    prod_u;
   logic [W2-1:0]    acc;
   logic             b_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] divisor_u;
   logic [WIDTH-1:0] divisor_s;
   logic [WIDTH-1:0] q_u;
   logic [WIDTH-1:0] r_u;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] r_s;

   // Products, and divides done on magnitudes so most-negative / -1 wraps cleanly
   always_comb begin
      prod_s    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      acc       = {hi, lo};
      b_zero    = (b == '0);
      a_mag     = a[WIDTH-1] ? WIDTH'(-a) : a;
      b_mag     = b[WIDTH-1] ? WIDTH'(-b) : b;
      divisor_u = b_zero ? WIDTH'(1) : b;
      divisor_s = b_zero ? WIDTH'(1) : b_mag;
      q_u       = a / divisor_u;
      r_u       = a % divisor_u;
      q_mag     = a_mag / divisor_s;
      r_mag     = a_mag % divisor_s;
      q_s       = (a[WIDTH-1] ^ b[WIDTH-1]) ? WIDTH'(-q_mag) : q_mag;
      r_s       = a[WIDTH-1] ? WIDTH'(-r_mag) : r_mag;
   end

   // Select the result for the requested op
   always_comb begin
      result_c = '0;
      case (op)
         OP_MULT:  result_c = prod_s;
         OP_MULTU: result_c = prod_u;
         OP_DIV:   result_c = b_zero ? {a, {WIDTH{1'b1}}} : {r_s, q_s};
         OP_DIVU:  result_c = b_zero ? {a, {WIDTH{1'b1}}} : {r_u, q_u};
         OP_MADD:  result_c = acc + prod_s;
         OP_MADDU: result_c = acc + prod_u;
         OP_MSUB:  result_c = acc - prod_s;
         OP_MSUBU: result_c = acc - prod_u;
         default:  result_c = '0;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by MDU_MADD_EN.
module mdu
   import mdu_defs::*;
#(
   parameter int unsigned WIDTH      = MDU_WIDTH_DEF,
   parameter int unsigned MUL_CYCLES = MDU_MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cancel,
   input  logic [3:0]       mdu_op,
   input  logic [WIDTH-1:0] mdu_input1,
   input  logic [WIDTH-1:0] mdu_input2,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mdu_out
);

   localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   result;
   logic [2*WIDTH-1:0]   arith_c;
   logic                 accept_c;
   logic                 is_arith_c;
   logic [CW-1:0]        cycles_c;

   assign accept_c = start & ~cancel & ~busy;

   mdu_arith #(
      .WIDTH    (WIDTH)
   ) u_arith (
      .op       (mdu_op),
      .a        (mdu_input1),
      .b        (mdu_input2),
      .hi       (hi),
      .lo       (lo),
      .result_c (arith_c)
   );

   // Classify the op: multi-cycle or not, and its latency
   always_comb begin
      is_arith_c = 1'b0;
      cycles_c   = CW'(MUL_CYCLES);
      case (mdu_op)
         OP_MULT, OP_MULTU: is_arith_c = 1'b1;
         OP_DIV, OP_DIVU: begin
            is_arith_c = 1'b1;
            cycles_c   = CW'(DIV_CYCLES);
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_arith_c = 1'b1;
`endif
         default: ;
      endcase
   end

   // Busy countdown, held result and HI/LO update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy   <= 1'b0;
         count  <= '0;
         result <= '0;
         hi     <= '0;
         lo     <= '0;
      end else if (busy) begin
         if (count == CW'(1)) begin
            hi    <= result[2*WIDTH-1:WIDTH];
            lo    <= result[WIDTH-1:0];
            busy  <= 1'b0;
            count <= '0;
         end else begin
            count <= count - CW'(1);
         end
      end else if (accept_c) begin
         if (is_arith_c) begin
            result <= arith_c;
            count  <= cycles_c;
            busy   <= 1'b1;
         end else if (mdu_op == OP_MTHI) begin
            hi <= mdu_input1;
         end else if (mdu_op == OP_MTLO) begin
            lo <= mdu_input1;
         end
      end
   end

   // Move-from read port
   always_comb begin
      mdu_out = '0;
      case (mdu_op)
         OP_MFHI: mdu_out = hi;
         OP_MFLO: mdu_out = lo;
         default: mdu_out = '0;
      endcase
   end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a plain-arithmetic model of HI/LO.
module tb_mdu;

   localparam int MULN = 5;
   localparam int DIVN = 10;

   localparam logic [3:0] T_MULT = 4'h0, T_MULTU = 4'h1, T_DIV = 4'h2, T_DIVU = 4'h3;
   localparam logic [3:0] T_MTHI = 4'h4, T_MTLO = 4'h5, T_MFHI = 4'h6, T_MFLO = 4'h7;
   localparam logic [3:0] T_MADD = 4'h8, T_MADDU = 4'h9, T_MSUB = 4'hA, T_MSUBU = 4'hB;
   localparam logic [3:0] T_NOP = 4'hF;

`ifdef MDU_MADD_EN
   localparam bit MADD_ON = 1'b1;
`else
   localparam bit MADD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cancel;
   logic [3:0]  mdu_op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu #(.WIDTH(32), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cancel     (cancel),
      .mdu_op     (mdu_op),
      .mdu_input1 (in1),
      .mdu_input2 (in2),
      .busy       (busy),
      .hi         (hi),
      .lo         (lo),
      .mdu_out    (mdu_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: what an accepted op does to {hi,lo}, and how long it takes
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] acc, output bit is_arith, output int n,
                                 output logic [63:0] res);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      is_arith = 1'b1;
      n = MULN;
      res = acc;
      case (op)
         T_MULT:  res = 64'(sa * sb);
         T_MULTU: res = ua * ub;
         T_DIV, T_DIVU: begin
            n = DIVN;
            if (b == 32'd0) res = {a, 32'hFFFFFFFF};
            else if (op == T_DIV) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end else begin
               q = longint'(ua / ub);
               r = longint'(ua % ub);
               res = {r[31:0], q[31:0]};
            end
         end
         T_MADD:  begin is_arith = MADD_ON; res = acc + 64'(sa * sb); end
         T_MADDU: begin is_arith = MADD_ON; res = acc + ua * ub; end
         T_MSUB:  begin is_arith = MADD_ON; res = acc - 64'(sa * sb); end
         T_MSUBU: begin is_arith = MADD_ON; res = acc - ua * ub; end
         default: is_arith = 1'b0;
      endcase
      if (!is_arith) res = acc;
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".busy"}, 64'(busy), 64'd0);
      check({tag, ".hi"}, 64'(hi), 64'(m_hi));
      check({tag, ".lo"}, 64'(lo), 64'(m_lo));
      mdu_op = T_MFHI; #1;
      check({tag, ".mfhi"}, 64'(mdu_out), 64'(m_hi));
      mdu_op = T_MFLO; #1;
      check({tag, ".mflo"}, 64'(mdu_out), 64'(m_lo));
      mdu_op = T_NOP; #1;
      check({tag, ".out0"}, 64'(mdu_out), 64'd0);
   endtask

   // Issue one op, follow its busy window, then compare against the model
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cnl);
      bit arith;
      int n;
      logic [63:0] res;
      model(op, a, b, {m_hi, m_lo}, arith, n, res);
      @(negedge clk);
      start = 1'b1; cancel = cnl; mdu_op = op; in1 = a; in2 = b;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0; mdu_op = T_NOP;
      if (!cnl && arith) begin
         for (int i = 0; i < n; i++) begin
            check({tag, ".busy_on"}, 64'(busy), 64'd1);
            if (i == 0 || i == n - 1) begin
               check({tag, ".hold_hi"}, 64'(hi), 64'(m_hi));
               check({tag, ".hold_lo"}, 64'(lo), 64'(m_lo));
            end
            @(posedge clk); #1;
         end
         m_hi = res[63:32];
         m_lo = res[31:0];
      end else if (!cnl && op == T_MTHI) begin
         m_hi = a;
      end else if (!cnl && op == T_MTLO) begin
         m_lo = a;
      end
      check_state(tag);
   endtask

   task automatic expect_hl(input string tag, input logic [31:0] h, input logic [31:0] l);
      check({tag, ".hi_const"}, 64'(hi), 64'(h));
      check({tag, ".lo_const"}, 64'(lo), 64'(l));
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'(int'($urandom_range(0, 20)));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b0; start = 1'b0; cancel = 1'b0; mdu_op = T_NOP; in1 = '0; in2 = '0;
      m_hi = '0; m_lo = '0;
      #2;
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.hi", 64'(hi), 64'd0);
      check("reset.lo", 64'(lo), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_op("mult", T_MULT, 32'hFFFFFFFE, 32'h3, 1'b0);
      expect_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu", T_MULTU, 32'hFFFFFFFE, 32'h3, 1'b0);
      expect_hl("multu", 32'h00000002, 32'hFFFFFFFA);
      run_op("div", T_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
      expect_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu", T_DIVU, 32'd7, 32'd2, 1'b0);
      expect_hl("divu", 32'd1, 32'd3);
      run_op("divu0", T_DIVU, 32'h1234, 32'd0, 1'b0);
      expect_hl("divu0", 32'h1234, 32'hFFFFFFFF);
      run_op("div_ovf", T_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      expect_hl("div_ovf", 32'd0, 32'h80000000);

      // Starts during a busy window (one with cancel high) must be ignored
      begin
         bit arith;
         int n;
         logic [63:0] res;
         model(T_MULT, 32'd1000, 32'hFFFFFFF0, {m_hi, m_lo}, arith, n, res);
         @(negedge clk);
         start = 1'b1; mdu_op = T_MULT; in1 = 32'd1000; in2 = 32'hFFFFFFF0;
         @(posedge clk); #1;
         @(negedge clk);
         mdu_op = T_DIV; in1 = 32'd9; in2 = 32'd4; cancel = 1'b1;
         @(posedge clk); #1;
         check("ovl.busy1", 64'(busy), 64'd1);
         @(negedge clk);
         mdu_op = T_MTHI; in1 = 32'hAAAA; cancel = 1'b0;
         @(posedge clk); #1;
         start = 1'b0; mdu_op = T_NOP;
         check("ovl.busy2", 64'(busy), 64'd1);
         repeat (2) begin
            @(posedge clk); #1;
            check("ovl.busy_tail", 64'(busy), 64'd1);
         end
         @(posedge clk); #1;
         m_hi = res[63:32];
         m_lo = res[31:0];
         check_state("ovl");
      end

      run_op("mtlo_cancel", T_MTLO, 32'd5, 32'd0, 1'b1);
      run_op("mthi", T_MTHI, 32'h1234, 32'd0, 1'b0);
      run_op("mtlo", T_MTLO, 32'h5678, 32'd0, 1'b0);

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; mdu_op = T_DIV; in1 = 32'd100; in2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; mdu_op = T_NOP;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst.busy", 64'(busy), 64'd0);
      check("arst.hi", 64'(hi), 64'd0);
      check("arst.lo", 64'(lo), 64'd0);
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (DIVN) @(posedge clk);
      #1;
      check_state("arst_after");

      run_op("madd_hi", T_MTHI, 32'd0, 32'd0, 1'b0);
      run_op("madd_lo", T_MTLO, 32'd5, 32'd0, 1'b0);
      run_op("madd", T_MADD, 32'd2, 32'd3, 1'b0);
      if (MADD_ON) expect_hl("madd", 32'd0, 32'd11);
      else         expect_hl("madd", 32'd0, 32'd5);
      run_op("msubu", T_MSUBU, 32'd4, 32'd4, 1'b0);
      if (MADD_ON) expect_hl("msubu", 32'hFFFFFFFF, 32'hFFFFFFFB);
      else         expect_hl("msubu", 32'd0, 32'd5);

      for (int k = 0; k < 60; k++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         run_op("rand", op, pick_operand(), pick_operand(), ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX beside the ALU.
- Executes MULT/MULTU/DIV/DIVU with configurable latency and handles MTHI/MTLO/MFHI/MFLO.
- Drives a busy flag that the hazard unit uses to stall later HI/LO-touching instructions.
- Accepts a cancel input so an exception flushing the issuing instruction suppresses its side effects.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); must be >= 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- start  in  1  issue strobe for the op in mdu_op.
- cancel  in  1  the issuing instruction is being flushed; suppresses start and MT writes in the same cycle.
- mdu_op  in  4  operation code (encodings in the package).
- mdu_input1  in  WIDTH  rs operand: dividend, or multiplicand, or MT data.
- mdu_input2  in  WIDTH  rt operand: divisor or multiplier.
- busy  out  1  operation in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mdu_out  out  WIDTH  read result: hi for MFHI, lo for MFLO, 0 otherwise.

Behaviour:
- Reset (reset low, asynchronous): busy=0, hi=0, lo=0, cycle counter=0, pending result=0. Any operation in flight is discarded.
- Accept condition: accept = start & ~cancel & ~busy.
  - start while busy is ignored; the stall logic guarantees this never happens.
  - start with cancel has no effect at all.
- Arithmetic ops (MULT/MULTU/DIV/DIVU) accepted at edge T:
  - The 2*WIDTH result is computed from the operands sampled at T and held in an internal result register.
  - The counter is loaded with MUL_CYCLES or DIV_CYCLES.
  - busy=1 for exactly N cycles after edge T.
  - At edge T+N: hi/lo take the held result and busy falls in the same edge.
  - hi/lo keep their old values throughout the busy window.
- MULT: signed WIDTH x WIDTH product. {hi,lo} = 2*WIDTH product.
- MULTU: unsigned WIDTH x WIDTH product. {hi,lo} = 2*WIDTH product.
- DIV (signed): lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - Most-negative / -1: lo = most-negative, hi = 0 (wraps).
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (DIV and DIVU): lo = all ones, hi = dividend. Latency is still DIV_CYCLES.
- MTHI/MTLO: accepted under the same accept condition.
  - Written at the next edge, single cycle, busy stays 0.
  - Ignored while busy.
- MFHI/MFLO: combinational via mdu_out. No state change; start is not required.
  - While busy, mdu_out returns the stale value; the hazard unit stalls to prevent such reads.
- Unused opcodes: no effect.
- cancel asserted mid-operation is ignored; the accepted op completes.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU.
  - {hi,lo} = {hi,lo} ± product (signed or unsigned product), computed from the hi/lo values at accept.
  - Latency MUL_CYCLES; result wraps mod 2^(2*WIDTH).
- Undefined: those opcodes behave as unused (no effect, busy stays 0).

Decomposition:
- Package mdu_defs holds the op encodings:
  - MULT 0000, MULTU 0001, DIV 0010, DIVU 0011
  - MTHI 0100, MTLO 0101, MFHI 0110, MFLO 0111
  - MADD 1000, MADDU 1001, MSUB 1010, MSUBU 1011
  - NOP 1111
- Package mdu_defs also holds the default latency constants.
- Sub-module mdu_arith: purely combinational 2*WIDTH result for a given op, operands and current hi/lo, including the divide-by-zero rule.
- The top holds the counter, busy flag, result register and HI/LO.

Test Plan (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10):
- MULT 0xFFFFFFFE x 0x00000003 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 / 0x00000002 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
- DIVU 0x00001234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a MULT busy window: second start (DIV) and MTHI 0xAAAA are both ignored; hi/lo reflect only the MULT. start+cancel with MTLO 5 -> lo unchanged, busy=0.
- reset driven low 4 cycles into a DIV -> busy, hi, lo read 0 immediately, before the next clock edge; after release, MFLO returns 0.
- With MDU_MADD_EN: MTHI 0, MTLO 5, then MADD 2x3 -> lo=11 after 5 cycles; MSUBU 4x4 -> {hi,lo}=0xFFFFFFFF_FFFFFFFB. Without the macro, same sequence -> lo stays 5, busy never rises.
